// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

   localparam int MEM_ARB_ADDR_W = 30;
   localparam int MEM_ARB_DATA_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_t;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the processor-side ports (InstMem_*, DataMem_*) and the unified
// memory bus (Mem_*). "slave" is the arbiter's view; "master" is the view of
// the environment (processor plus memory model).
interface mem_arbiter_if import mem_arb_pkg::*; #(
   parameter int ADDR_W = MEM_ARB_ADDR_W,
   parameter int DATA_W = MEM_ARB_DATA_W
);
   logic              InstMem_Read;
   logic [ADDR_W-1:0] InstMem_Address;
   logic [DATA_W-1:0] InstMem_In;
   logic              InstMem_Ack;

   logic              DataMem_Read;
   logic [3:0]        DataMem_Write;
   logic [ADDR_W-1:0] DataMem_Address;
   logic [DATA_W-1:0] DataMem_Out;
   logic [DATA_W-1:0] DataMem_In;
   logic              DataMem_Ack;

   logic              Mem_Read;
   logic [3:0]        Mem_Write;
   logic [ADDR_W-1:0] Mem_Address;
   logic [DATA_W-1:0] Mem_WrData;
   logic [DATA_W-1:0] Mem_RdData;
   logic              Mem_Ack;

   modport slave (
      input  InstMem_Read, InstMem_Address,
      input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
      input  Mem_RdData, Mem_Ack,
      output InstMem_In, InstMem_Ack, DataMem_In, DataMem_Ack,
      output Mem_Read, Mem_Write, Mem_Address, Mem_WrData
   );

   modport master (
      output InstMem_Read, InstMem_Address,
      output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
      output Mem_RdData, Mem_Ack,
      input  InstMem_In, InstMem_Ack, DataMem_In, DataMem_Ack,
      input  Mem_Read, Mem_Write, Mem_Address, Mem_WrData
   );

endinterface

// File: rtl/mem_arb_select.sv
// Winner selection for the arbiter. Default build: fixed data-over-instruction
// priority. With MEM_ARB_ROUND_ROBIN_EN defined, a last-grant register makes
// simultaneous requests alternate; a lone request always wins.
module mem_arb_select import mem_arb_pkg::*; (
   input  logic clock,
   input  logic reset,
   input  logic ireq_i,
   input  logic dreq_i,
   input  logic grant_i,
   output logic owner_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_q;

   // Remember which port entered BUSY most recently.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_q <= OWN_INST;
      end else if (grant_i) begin
         last_q <= owner_o;
      end
   end

   // On a tie the port that was not granted last wins.
   always_comb begin
      owner_o = OWN_INST;
      if (dreq_i && ireq_i) begin
         owner_o = (last_q == OWN_DATA) ? OWN_INST : OWN_DATA;
      end else if (dreq_i) begin
         owner_o = OWN_DATA;
      end
   end
`else
   assign owner_o = dreq_i ? OWN_DATA : OWN_INST;

   // Clock, reset, fetch request and grant only matter for the fairness build.
   logic unused_sel;
   assign unused_sel = &{1'b0, clock, reset, ireq_i, grant_i};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one 32-bit memory bus between the instruction-fetch and data
// ports. Optional round-robin fairness: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_select).
//
// state    | meaning
// ARB_IDLE | no transaction; pick a winner and latch its request
// ARB_BUSY | Mem_* driven from latched registers, waiting for Mem_Ack
// ARB_DONE | owner's Ack pulsed for one cycle with the returned data
module mem_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_W = MEM_ARB_ADDR_W,
   parameter int DATA_W = MEM_ARB_DATA_W
) (
   input logic          clock,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   arb_state_t        state_q;
   logic              owner_q;
   logic              mem_read_q;
   logic [3:0]        mem_write_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              iack_q;
   logic              dack_q;

   logic ireq;
   logic dreq;
   logic grant;
   logic sel_owner;

   assign ireq  = bus.InstMem_Read;
   assign dreq  = bus.DataMem_Read | (|bus.DataMem_Write);
   assign grant = (state_q == ARB_IDLE) && (ireq || dreq);

   mem_arb_select u_select (
      .clock   (clock),
      .reset   (reset),
      .ireq_i  (ireq),
      .dreq_i  (dreq),
      .grant_i (grant),
      .owner_o (sel_owner)
   );

   // Arbitration FSM with registered bus strobes, acks and return data.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         owner_q     <= OWN_DATA;
         mem_read_q  <= 1'b0;
         mem_write_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         iack_q      <= 1'b0;
         dack_q      <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (grant) begin
                  owner_q <= sel_owner;
                  state_q <= ARB_BUSY;
                  if (sel_owner == OWN_DATA) begin
                     // A write request overrides a simultaneous read.
                     mem_read_q  <= ~(|bus.DataMem_Write);
                     mem_write_q <= bus.DataMem_Write;
                     mem_addr_q  <= bus.DataMem_Address;
                     mem_wdata_q <= bus.DataMem_Out;
                  end else begin
                     mem_read_q  <= 1'b1;
                     mem_write_q <= '0;
                     mem_addr_q  <= bus.InstMem_Address;
                     mem_wdata_q <= '0;
                  end
               end
            end
            ARB_BUSY: begin
               if (bus.Mem_Ack) begin
                  rdata_q     <= bus.Mem_RdData;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= '0;
                  iack_q      <= (owner_q == OWN_INST);
                  dack_q      <= (owner_q == OWN_DATA);
                  state_q     <= ARB_DONE;
               end
            end
            ARB_DONE: begin
               iack_q  <= 1'b0;
               dack_q  <= 1'b0;
               state_q <= ARB_IDLE;
            end
            default: begin
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   assign bus.Mem_Read    = mem_read_q;
   assign bus.Mem_Write   = mem_write_q;
   assign bus.Mem_Address = mem_addr_q;
   assign bus.Mem_WrData  = mem_wdata_q;
   assign bus.InstMem_In  = rdata_q;
   assign bus.DataMem_In  = rdata_q;
   assign bus.InstMem_Ack = iack_q;
   assign bus.DataMem_Ack = dack_q;

endmodule
